writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter DATA_W, default 64, datapath width.
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 Parameter ZERO_REG, default 31, hard-wired zero register index.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 mem_valid  in  1  MEM stage holds a live instruction.
REQ-007 mem_regwrite  in  1  instruction writes a register.
REQ-008 mem_memtoreg  in  1  1 = write load data, 0 = write ALU result.
REQ-009 mem_rd  in  ADDR_W  destination register.
REQ-010 mem_alu_result  in  DATA_W  ALU result from MEM.
REQ-011 mem_load_data  in  DATA_W  data-memory read value.
REQ-012 stall  in  1  hold MEM/WB register contents.
REQ-013 flush  in  1  kill incoming instruction.
REQ-014 RegWrite  out  1  regfile write enable.
REQ-015 WriteRegister  out  ADDR_W  regfile write address.
REQ-016 WriteData  out  DATA_W  regfile write data.
REQ-017 ReadRegister1, ReadRegister2  in  ADDR_W  ID-stage read addresses (also driven to regfile).
REQ-018 ReadData1, ReadData2  in  DATA_W  raw regfile read data.
REQ-019 BypassData1, BypassData2  out  DATA_W  read data corrected for the in-flight write.
REQ-020 retire_count  out  32  count of completed register writes.

Function
REQ-021 MEM/WB register SHALL hold wb_valid, wb_regwrite, wb_rd, wb_data; wb_data = mem_memtoreg ? mem_load_data : mem_alu_result, selected before the register (one-cycle latency MEM->WB).
REQ-022 On a clock edge: flush=1 -> wb_valid<=0, other fields don't-care; else stall=1 -> all fields hold; else all fields load from MEM inputs.
REQ-023 flush SHALL take priority over stall when both are asserted.
REQ-024 RegWrite SHALL equal wb_valid & wb_regwrite & (wb_rd != ZERO_REG), combinationally.
REQ-025 WriteRegister = wb_rd and WriteData = wb_data, unconditionally.
REQ-026 BypassDataN = 0 when ReadRegisterN == ZERO_REG; else WriteData when RegWrite & (WriteRegister == ReadRegisterN); else ReadDataN. Purely combinational, zero latency.
REQ-027 Both bypass ports SHALL resolve independently; equal addresses on both ports return the same value.
REQ-028 retire_count SHALL increment by 1 on each edge where RegWrite=1 and stall=0. A held (stalled) write therefore counts once, when it leaves WB.
REQ-029 retire_count SHALL wrap from 0xFFFF_FFFF to 0.
REQ-030 A write to ZERO_REG SHALL neither assert RegWrite nor increment retire_count.
REQ-031 mem_valid=0 SHALL load a bubble (wb_valid=0) when not stalled or flushed.

Reset
REQ-032 While reset=1, independent of clk: wb_valid=0, wb_regwrite=0, wb_rd=0, wb_data=0, retire_count=0, hence RegWrite=0, WriteRegister=0, WriteData=0.
REQ-033 Reset asserted mid-instruction SHALL discard the instruction with no regfile write; first capture after release on the next rising edge.

Structure
REQ-034 DATA_W, ADDR_W, ZERO_REG and the MEM/WB field struct SHALL live in the shared CPU package, also used by regfile and the ID/EX stage.
REQ-035 Bypass comparison SHALL be one sub-module, wb_bypass, instantiated twice (one per read port); the pipeline register and counter stay in writeback_stage.

Verification
REQ-036 Reset mid-write: mem_regwrite=1, mem_rd=3, reset pulse between edges -> RegWrite=0 and retire_count=0 immediately; X3 unchanged.
REQ-037 ALU vs load: rd=5, alu=0xA0, load=0x1234, memtoreg=0 then 1 on consecutive edges -> WriteData 0xA0 then 0x1234, RegWrite=1 both cycles, retire_count=2.
REQ-038 Zero register: mem_rd=31, regwrite=1, alu=0xA0 -> RegWrite=0; ReadRegister1=31 -> BypassData1=0; retire_count unchanged.
REQ-039 Bypass: WB writes X7=0x0000010204080001 while ReadRegister1=7, ReadRegister2=8 with regfile returning stale 0 and 0x55 -> BypassData1=0x0000010204080001, BypassData2=0x55.
REQ-040 Stall/flush: valid write to X2 held by stall for 3 cycles -> RegWrite=1 for 4 cycles, retire_count +1 only; stall=1 with flush=1 -> next cycle RegWrite=0.
REQ-041 Counter wrap: retire_count forced to 0xFFFF_FFFF, one valid write -> retire_count=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the zero register and the MEM/WB
// pipeline field layout used by the writeback stage, regfile and ID/EX stage.
package cpu_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] regAddr_t;

    typedef struct packed {
        logic     valid;
        logic     regwrite;
        regAddr_t rd;
        word_t    data;
    } memWb_t;

    localparam memWb_t MEMWB_RESET = '0;

    // Result mux sits in front of the MEM/WB register, so WB sees a single data field.
    function automatic word_t selectWbData(input logic memtoreg, input word_t aluResult,
                                           input word_t loadData);
        return memtoreg ? loadData : aluResult;
    endfunction

endpackage

// File: rtl/wb_bypass.sv
// One regfile read port corrected for the write currently in WB.
// The zero register always reads as 0, regardless of any write to it.
import cpu_pkg::*;

module wb_bypass #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
    input  logic [ADDR_W-1:0] ReadRegister,
    input  logic [DATA_W-1:0] ReadData,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] BypassData
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    // NOTE: every output of an always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        BypassData = ReadData;
        if (ReadRegister == ZERO_ADDR) begin
            BypassData = '0;
        end else if (RegWrite && (WriteRegister == ReadRegister)) begin
            BypassData = WriteData;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, regfile write port, read-port bypass and a
// counter of retired register writes.
import cpu_pkg::*;

module writeback_stage #(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic              mem_memtoreg,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_load_data,
    input  logic              stall,
    input  logic              flush,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] BypassData1,
    output logic [DATA_W-1:0] BypassData2,
    output logic [31:0]       retire_count
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    memWb_t memNext;
    memWb_t wb;

    always_comb begin
        memNext.valid    = mem_valid;
        memNext.regwrite = mem_regwrite;
        memNext.rd       = mem_rd;
        memNext.data     = selectWbData(mem_memtoreg, mem_alu_result, mem_load_data);
    end

    // Flush wins over stall; a flushed slot keeps its stale fields but is never valid.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb <= MEMWB_RESET;
        end else if (flush) begin
            wb.valid <= 1'b0;
        end else if (!stall) begin
            wb <= memNext;
        end
    end

    assign RegWrite      = wb.valid && wb.regwrite && (wb.rd != ZERO_ADDR);
    assign WriteRegister = wb.rd;
    assign WriteData     = wb.data;

    // A stalled write stays visible in WB for several cycles but retires only once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_count <= '0;
        end else if (RegWrite && !stall) begin
            retire_count <= retire_count + 32'd1;
        end
    end

    wb_bypass #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) bypass1 (
        .ReadRegister (ReadRegister1),
        .ReadData     (ReadData1),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .BypassData   (BypassData1)
    );

    wb_bypass #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) bypass2 (
        .ReadRegister (ReadRegister2),
        .ReadData     (ReadData2),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .BypassData   (BypassData2)
    );

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: reset, ALU/load select, zero register,
// bypass, stall/flush, mid-write reset and counter wrap.
module tb_writeback_stage;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic        mem_regwrite;
    logic        mem_memtoreg;
    logic [4:0]  mem_rd;
    logic [63:0] mem_alu_result;
    logic [63:0] mem_load_data;
    logic        stall;
    logic        flush;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;
    logic [63:0] BypassData1;
    logic [63:0] BypassData2;
    logic [31:0] retire_count;

    int passCount  = 0;
    int totalCount = 0;

    writeback_stage dut (
        .clk           (clk),
        .reset         (reset),
        .mem_valid     (mem_valid),
        .mem_regwrite  (mem_regwrite),
        .mem_memtoreg  (mem_memtoreg),
        .mem_rd        (mem_rd),
        .mem_alu_result(mem_alu_result),
        .mem_load_data (mem_load_data),
        .stall         (stall),
        .flush         (flush),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .BypassData1   (BypassData1),
        .BypassData2   (BypassData2),
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic driveMem(input logic valid, input logic regwrite, input logic memtoreg,
                            input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] load);
        mem_valid      = valid;
        mem_regwrite   = regwrite;
        mem_memtoreg   = memtoreg;
        mem_rd         = rd;
        mem_alu_result = alu;
        mem_load_data  = load;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        driveMem(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd0;
        ReadData1     = 64'd0;
        ReadData2     = 64'd0;

        // Reset state, sampled before any clock edge.
        #2;
        check("reset_regwrite", 64'(RegWrite), 64'd0);
        check("reset_wreg", 64'(WriteRegister), 64'd0);
        check("reset_wdata", WriteData, 64'd0);
        check("reset_count", 64'(retire_count), 64'd0);
        step();
        step();
        reset = 1'b0;

        // ALU result then load data into X5 on consecutive edges.
        driveMem(1'b1, 1'b1, 1'b0, 5'd5, 64'hA0, 64'h1234);
        step();
        check("alu_wdata", WriteData, 64'hA0);
        check("alu_regwrite", 64'(RegWrite), 64'd1);
        check("alu_wreg", 64'(WriteRegister), 64'd5);
        check("alu_count", 64'(retire_count), 64'd0);
        mem_memtoreg = 1'b1;
        step();
        check("load_wdata", WriteData, 64'h1234);
        check("load_regwrite", 64'(RegWrite), 64'd1);
        check("load_count", 64'(retire_count), 64'd1);
        mem_valid = 1'b0;
        step();
        check("bubble_regwrite", 64'(RegWrite), 64'd0);
        check("alu_load_count", 64'(retire_count), 64'd2);

        // Valid instruction that does not write a register.
        driveMem(1'b1, 1'b0, 1'b0, 5'd6, 64'h66, 64'd0);
        step();
        check("noregwrite_regwrite", 64'(RegWrite), 64'd0);

        // Write aimed at the zero register.
        driveMem(1'b1, 1'b1, 1'b0, 5'd31, 64'hA0, 64'd0);
        ReadRegister1 = 5'd31;
        ReadData1     = 64'hDEAD;
        step();
        check("zero_regwrite", 64'(RegWrite), 64'd0);
        check("zero_wreg", 64'(WriteRegister), 64'd31);
        check("zero_bypass1", BypassData1, 64'd0);
        mem_valid = 1'b0;
        step();
        check("zero_count", 64'(retire_count), 64'd2);

        // Bypass of an in-flight write to X7; port 2 reads X8 then X7.
        driveMem(1'b1, 1'b1, 1'b0, 5'd7, 64'h0000010204080001, 64'd0);
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd8;
        ReadData1     = 64'd0;
        ReadData2     = 64'h55;
        step();
        check("bypass_hit1", BypassData1, 64'h0000010204080001);
        check("bypass_miss2", BypassData2, 64'h55);
        ReadRegister2 = 5'd7;
        #1;
        check("bypass_same_addr2", BypassData2, 64'h0000010204080001);
        mem_valid = 1'b0;
        step();
        check("bypass_after_write1", BypassData1, 64'd0);
        check("bypass_count", 64'(retire_count), 64'd3);

        // Write to X2 held by three stall cycles; changed MEM inputs must not leak in.
        driveMem(1'b1, 1'b1, 1'b0, 5'd2, 64'h22, 64'd0);
        step();
        check("stall_load_regwrite", 64'(RegWrite), 64'd1);
        stall = 1'b1;
        driveMem(1'b1, 1'b1, 1'b0, 5'd9, 64'h99, 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_regwrite", 64'(RegWrite), 64'd1);
            check("stall_hold_wreg", 64'(WriteRegister), 64'd2);
            check("stall_hold_wdata", WriteData, 64'h22);
            check("stall_hold_count", 64'(retire_count), 64'd3);
        end
        stall = 1'b0;
        mem_valid = 1'b0;
        step();
        check("stall_release_regwrite", 64'(RegWrite), 64'd0);
        check("stall_release_count", 64'(retire_count), 64'd4);

        // Flush beats stall.
        driveMem(1'b1, 1'b1, 1'b0, 5'd2, 64'h23, 64'd0);
        step();
        check("flush_pre_regwrite", 64'(RegWrite), 64'd1);
        stall = 1'b1;
        flush = 1'b1;
        step();
        check("stall_flush_regwrite", 64'(RegWrite), 64'd0);
        check("stall_flush_count", 64'(retire_count), 64'd4);
        stall = 1'b0;

        // Flush alone kills the incoming write.
        driveMem(1'b1, 1'b1, 1'b0, 5'd4, 64'h44, 64'd0);
        step();
        check("flush_regwrite", 64'(RegWrite), 64'd0);
        flush = 1'b0;

        // Reset pulse between edges while X3 is being written.
        driveMem(1'b1, 1'b1, 1'b0, 5'd3, 64'h33, 64'd0);
        step();
        check("midreset_pre_regwrite", 64'(RegWrite), 64'd1);
        check("midreset_pre_count", 64'(retire_count), 64'd4);
        #1;
        reset = 1'b1;
        #1;
        check("midreset_regwrite", 64'(RegWrite), 64'd0);
        check("midreset_count", 64'(retire_count), 64'd0);
        check("midreset_wdata", WriteData, 64'd0);
        reset = 1'b0;
        step();
        check("midreset_capture_regwrite", 64'(RegWrite), 64'd1);
        check("midreset_capture_count", 64'(retire_count), 64'd0);
        mem_valid = 1'b0;
        step();
        check("midreset_retire_count", 64'(retire_count), 64'd1);

        // Counter wrap from all-ones.
        force dut.retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count;
        driveMem(1'b1, 1'b1, 1'b0, 5'd6, 64'h66, 64'd0);
        step();
        check("wrap_pre_count", 64'(retire_count), 64'hFFFF_FFFF);
        mem_valid = 1'b0;
        step();
        check("wrap_count", 64'(retire_count), 64'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
